// File: rtl/sumador_serial_p.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flip-flop,
// LSB first, WIDTH cycles per operation behind a start/ready handshake.
module sumador_serial_p #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow,
  output logic             valid
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               sum_bit;
  logic               carry_nxt;
  logic               last_bit;

  assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

  // NOTE: every variable gets a hold default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          r_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        r_d     = {sum_bit, r_q[WIDTH-1:1]};
        carry_d = carry_nxt;
        if (last_bit) begin
          // carry_q here is the carry into the MSB, so overflow needs no extra flop.
          s_d     = {sum_bit, r_q[WIDTH-1:1]};
          cout_d  = carry_nxt;
          ovf_d   = carry_q ^ carry_nxt;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state, including the data shift registers, is reset so an aborted
  // operation leaves nothing behind; sequential updates use <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign valid    = (state_q == DONE);
  assign s        = s_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_sumador_serial_p.sv
// Self-checking bench for sumador_serial_p: 8-bit and 16-bit instances checked
// against an integer-arithmetic reference model.
module tb_sumador_serial_p;

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [15:0] s;
  } res_t;

  logic        clk;
  logic        rst_n;

  logic        start8, cin8, sub8, ready8, cout8, ovf8, valid8;
  logic [7:0]  a8, b8, s8;
  logic        start16, cin16, sub16, ready16, cout16, ovf16, valid16;
  logic [15:0] a16, b16, s16;

  int n_tests;
  int n_fail;

  sumador_serial_p #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .ready(ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .s(s8), .cout(cout8), .overflow(ovf8), .valid(valid8)
  );

  sumador_serial_p #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .ready(ready16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .s(s16), .cout(cout16), .overflow(ovf16), .valid(valid16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact integer arithmetic: unsigned result for s/cout, signed for overflow.
  function automatic res_t model(input int w, input longint ua, input longint ub,
                                 input bit tc, input bit ts);
    longint m, h, sa, sb, u, sg;
    res_t   r;
    m  = longint'(1) << w;
    h  = m / 2;
    sa = (ua >= h) ? ua - m : ua;
    sb = (ub >= h) ? ub - m : ub;
    u  = ts ? ua - ub - longint'(tc) : ua + ub + longint'(tc);
    sg = ts ? sa - sb - longint'(tc) : sa + sb + longint'(tc);
    r.s    = 16'(((u % m) + m) % m);
    r.cout = ts ? (u >= 0) : (u >= m);
    r.ovf  = (sg < -h) || (sg >= h);
    return r;
  endfunction

  task automatic wait_ready8();
    int i;
    for (i = 0; i < 50 && !ready8; i++) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if (ready8 !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_ready8: ready=%b after %0d cycles, required 1", ready8, i);
    end
  endtask

  // One 8-bit operation; glitch_at>0 pulses start with a=0x11 in that RUN cycle.
  task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input logic ts, input int glitch_at, input string name);
    res_t        e;
    logic [9:0]  prev;
    int          pulses, lat;
    bit          held, busy;
    e = model(8, longint'(ta), longint'(tb_), tc, ts);
    wait_ready8();
    @(negedge clk);
    a8 = ta; b8 = tb_; cin8 = tc; sub8 = ts; start8 = 1'b1;
    prev = {s8, cout8, ovf8};
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    pulses = 0; lat = 0; held = 1'b1; busy = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      if (i == glitch_at) begin
        start8 = 1'b1; a8 = 8'h11;
      end else begin
        start8 = 1'b0;
      end
      if (valid8) begin
        pulses++;
        if (lat == 0) lat = i;
      end
      if (i < 8 && {s8, cout8, ovf8} !== prev) held = 1'b0;
      if (i <= 8 && ready8 !== 1'b0) busy = 1'b0;
    end
    n_tests++;
    if ({s8, cout8, ovf8} !== {e.s[7:0], e.cout, e.ovf}) begin
      n_fail++;
      $display("FAIL %s result: s=%h cout=%b ovf=%b, required s=%h cout=%b ovf=%b",
               name, s8, cout8, ovf8, e.s[7:0], e.cout, e.ovf);
    end
    n_tests++;
    if (pulses != 1 || lat != 8) begin
      n_fail++;
      $display("FAIL %s valid: %0d pulses at cycle %0d, required 1 pulse at cycle 8",
               name, pulses, lat);
    end
    n_tests++;
    if (!held || !busy || ready8 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s hold/ready: held=%b busy=%b ready=%b, required 1 1 1",
               name, held, busy, ready8);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
    start16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if ({ready8, valid8, s8, cout8, ovf8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset8: ready=%b valid=%b s=%h cout=%b ovf=%b, required 1 0 00 0 0",
               ready8, valid8, s8, cout8, ovf8);
    end
    n_tests++;
    if ({ready16, valid16, s16, cout16, ovf16} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset16: ready=%b valid=%b s=%h cout=%b ovf=%b, required 1 0 0000 0 0",
               ready16, valid16, s16, cout16, ovf16);
    end
  endtask

  task automatic test_directed();
    do_op8(8'h5A, 8'h3C, 1'b0, 1'b0, 0, "add_5a_3c");
    do_op8(8'hFF, 8'h01, 1'b1, 1'b0, 0, "add_wrap");
    do_op8(8'h10, 8'h20, 1'b0, 1'b1, 0, "sub_borrow");
    do_op8(8'h80, 8'h01, 1'b0, 1'b1, 0, "sub_ovf");
    do_op8(8'h00, 8'h00, 1'b1, 1'b1, 0, "sub_zero_bin");
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++)
      do_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0, "random");
  endtask

  task automatic test_ignore_start();
    do_op8(8'h5A, 8'h3C, 1'b0, 1'b0, 3, "ignore_start");
  endtask

  task automatic test_mid_reset();
    int pulses;
    wait_ready8();
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'h3C; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ready8, valid8, s8, cout8, ovf8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset outputs: ready=%b valid=%b s=%h cout=%b ovf=%b, required 1 0 00 0 0",
               ready8, valid8, s8, cout8, ovf8);
    end
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (valid8) pulses++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (valid8) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL mid_reset discard: %0d valid pulses, required 0", pulses);
    end
    do_op8(8'hC3, 8'h7E, 1'b0, 1'b1, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    res_t expq[$];
    res_t e;
    int   pushed, got, last_v, cyc;
    wait_ready8();
    @(negedge clk);
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    start8 = 1'b1;
    expq.push_back(model(8, longint'(a8), longint'(b8), cin8, sub8));
    pushed = 1; got = 0; last_v = -1;
    for (cyc = 0; cyc < 200 && got < 6; cyc++) begin
      @(posedge clk); #1;
      if (valid8) begin
        e = expq.pop_front();
        got++;
        n_tests++;
        if ({s8, cout8, ovf8} !== {e.s[7:0], e.cout, e.ovf}) begin
          n_fail++;
          $display("FAIL b2b result %0d: s=%h cout=%b ovf=%b, required s=%h cout=%b ovf=%b",
                   got, s8, cout8, ovf8, e.s[7:0], e.cout, e.ovf);
        end
        if (last_v >= 0) begin
          n_tests++;
          if (cyc - last_v != 10) begin
            n_fail++;
            $display("FAIL b2b spacing %0d: %0d cycles, required 10", got, cyc - last_v);
          end
        end
        last_v = cyc;
      end
      if (ready8 && pushed < 6) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
        expq.push_back(model(8, longint'(a8), longint'(b8), cin8, sub8));
        pushed++;
      end else if (ready8) begin
        start8 = 1'b0;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
    end
    start8 = 1'b0;
    n_tests++;
    if (got != 6) begin
      n_fail++;
      $display("FAIL b2b count: %0d results in %0d cycles, required 6", got, cyc);
    end
  endtask

  task automatic test_w16();
    logic [15:0] va[3] = '{16'hFFFF, 16'h8000, 16'h1234};
    logic [15:0] vb[3] = '{16'h0001, 16'h0001, 16'hABCD};
    logic        vs[3] = '{1'b0, 1'b1, 1'b1};
    res_t        e;
    int          lat;
    for (int k = 0; k < 3; k++) begin
      e = model(16, longint'(va[k]), longint'(vb[k]), 1'b0, vs[k]);
      @(negedge clk);
      a16 = va[k]; b16 = vb[k]; cin16 = 1'b0; sub16 = vs[k]; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
      lat = 0;
      for (int i = 1; i <= 40 && lat == 0; i++) begin
        @(posedge clk); #1;
        if (valid16) lat = i;
      end
      n_tests++;
      if (lat != 16 || {s16, cout16, ovf16} !== {e.s, e.cout, e.ovf}) begin
        n_fail++;
        $display("FAIL w16 op %0d: lat=%0d s=%h cout=%b ovf=%b, required lat=16 s=%h cout=%b ovf=%b",
                 k, lat, s16, cout16, ovf16, e.s, e.cout, e.ovf);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_w16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sumador_serial_p.md
Name: sumador_serial_p

Overview:
Parametrised true bit-serial adder/subtractor. Processes one bit per clock, LSB first, through a single full-adder slice and a carry flip-flop. It replaces the combinational ripple adder wherever area matters more than latency. Operands are captured with a start/ready handshake; the result is reported with a one-cycle valid pulse, and s/cout/overflow are held stable until the next accepted operation.

Parameters:
WIDTH, 8, operand/result width in bits; legal range >= 2
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request new operation; accepted only when ready=1
ready  output  1  block idle, able to accept start
a  input  WIDTH  operand A, sampled on accepted start
b  input  WIDTH  operand B, sampled on accepted start
cin  input  1  carry-in (add) / borrow-in (sub), sampled on accepted start
sub  input  1  0=add, 1=subtract, sampled on accepted start
s  output  WIDTH  result, registered, held until the next result
cout  output  1  carry-out (add); NOT borrow (sub): 1 = no borrow
overflow  output  1  two's-complement signed overflow
valid  output  1  one-cycle pulse, result just updated

Behaviour:
- Reset (rst_n=0, asynchronous, any time incl. mid-operation):
  - state=IDLE; all shift registers, counter and carry FF cleared.
  - s=0, cout=0, overflow=0, valid=0, ready=1.
  - An in-flight operation is discarded with no valid pulse.
- States: IDLE, RUN, DONE.
  - ready = (state==IDLE), decoded from registered state only.
- IDLE:
  - On an edge with start=1: load a into shift register A and b (or ~b when sub=1) into shift register B.
  - Load the carry FF with cin when sub=0, or ~cin when sub=1. Clear the counter; go to RUN.
  - start=0 → remain IDLE.
- Arithmetic:
  - sub=0: {cout,s} = a + b + cin.
  - sub=1: {cout,s} = a + ~b + ~cin, i.e. a - b - cin.
  - Result is modulo 2^WIDTH.
- RUN, each edge:
  - sum bit = A[0]^B[0]^carry; new carry = majority(A[0],B[0],carry).
  - Sum bit shifts into the MSB of the result shift register; A and B shift right; counter increments.
  - The carry into bit WIDTH-1 is captured for overflow.
  - On the edge where counter==WIDTH-1 (the last bit), update s from the result register plus the final sum bit, cout=final carry, overflow = carry_into_msb ^ final carry; set valid=1; go to DONE.
- DONE: lasts exactly one cycle. valid=1 and ready=0; next edge valid=0 → IDLE.
- Latency and throughput:
  - Accepting edge k → valid high in the cycle after edge k+WIDTH.
  - One operation per WIDTH+2 cycles.
- Boundary conditions:
  - start while ready=0 (RUN/DONE) is ignored; operands are not resampled.
  - Input changes after acceptance have no effect.
  - s/cout/overflow never change except on the completion edge or under reset.
  - start held high continuously → back-to-back operations, each accepted on the IDLE edge.
  - Counter does not wrap inside an operation; it is cleared on every accept.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release → ready=1, valid=0, s=0x00, cout=0, overflow=0.
- Add, WIDTH=8: a=0x5A, b=0x3C, cin=0, sub=0 → after 8 cycles valid pulse for exactly 1 cycle, s=0x96, cout=0, overflow=1. ready returns 1 two cycles after the last bit.
- Add with carry wrap: a=0xFF, b=0x01, cin=1 → s=0x01, cout=1, overflow=0.
- Subtract:
  - a=0x10, b=0x20, cin=0, sub=1 → s=0xF0, cout=0 (borrow), overflow=0.
  - a=0x80, b=0x01, cin=0, sub=1 → s=0x7F, cout=1, overflow=1.
- Protocol:
  - Pulse start with a=0x11 during RUN of 0x5A+0x3C → ignored; result still 0x96, exactly one valid.
  - Assert rst_n=0 at bit 4 of an operation → no valid; outputs 0; a new op afterwards completes correctly.
- WIDTH=16 instance: a=0xFFFF, b=0x0001, cin=0 → valid 16 cycles after the accept edge, s=0x0000, cout=1, overflow=0.
